// File: rtl/softmax_norm.sv
// rtl/softmax_norm.sv - collects N exp words, sums them, emits exp_i/sum as Q0.16 (SOFTMAX_NORM_ROUND_EN: rounded 17-bit quotient)
module softmax_norm #(
    parameter int N = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [20:0] in_exp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_prob,
    output logic        out_last,
    output logic        busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = 32 + CW;
    localparam int RW = AW + 1;
`ifdef SOFTMAX_NORM_ROUND_EN
    localparam int QB = 17;
`else
    localparam int QB = 16;
`endif
    localparam logic [1:0]    S_ACCUM   = 2'd0;
    localparam logic [1:0]    S_DIV     = 2'd1;
    localparam logic [1:0]    S_OUT     = 2'd2;
    localparam logic [4:0]    LAST_ITER = 5'(QB);
    localparam logic [CW-1:0] LAST_IDX  = CW'(N - 1);

    logic [1:0]    state;
    logic [CW-1:0] count;
    logic [CW-1:0] idx;
    logic [AW-1:0] acc;
    logic [AW-1:0] divisor;
    logic [AW-1:0] rem;
    logic [QB-1:0] quo;
    logic [4:0]    div_cnt;
    logic [31:0]   vec_buf [N];

    logic [4:0]    p_clamp;
    logic [31:0]   fixed;
    logic          accept;
    logic [RW-1:0] rem_sh;
    logic          ge;
    logic [QB-1:0] quo_nx;
    logic [15:0]   prob_nx;
`ifdef SOFTMAX_NORM_ROUND_EN
    logic [QB:0]   q_inc;
`endif

    assign in_ready = (state == S_ACCUM);
    assign busy     = !((state == S_ACCUM) && (count == '0));

    always_comb begin
        p_clamp = (in_exp[20:16] > 5'd16) ? 5'd16 : in_exp[20:16];
        fixed   = {16'd0, in_exp[15:0]} << p_clamp;
        accept  = in_valid && in_ready;
        rem_sh  = {rem, 1'b0};
        ge      = (rem_sh >= {1'b0, divisor});
        quo_nx  = {quo[QB-2:0], ge};
        prob_nx = 16'd0;
`ifdef SOFTMAX_NORM_ROUND_EN
        // Extra quotient bit gives the half-LSB; a carry into bit 16 saturates.
        q_inc = {1'b0, quo_nx} + 1'b1;
        if (divisor != '0)
            prob_nx = q_inc[QB] ? 16'hFFFF : q_inc[16:1];
`else
        // dividend == divisor keeps subtracting, so all-ones falls out naturally.
        if (divisor != '0)
            prob_nx = quo_nx;
`endif
    end

    always_ff @(posedge clk) begin
        if (accept)
            vec_buf[count] <= fixed;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_ACCUM;
            count     <= '0;
            idx       <= '0;
            acc       <= '0;
            divisor   <= '0;
            rem       <= '0;
            quo       <= '0;
            div_cnt   <= '0;
            out_valid <= 1'b0;
            out_prob  <= 16'd0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                S_ACCUM: begin
                    if (accept) begin
                        acc   <= acc + AW'(fixed);
                        count <= count + 1'b1;
                        if (count == LAST_IDX) begin
                            state <= S_DIV;
                            idx   <= '0;
                        end
                    end
                end
                S_DIV: begin
                    if (div_cnt == 5'd0) begin
                        rem     <= AW'(vec_buf[idx]);
                        divisor <= acc;
                        quo     <= '0;
                        div_cnt <= 5'd1;
                    end else begin
                        rem <= AW'(ge ? (rem_sh - {1'b0, divisor}) : rem_sh);
                        quo <= quo_nx;
                        if (div_cnt == LAST_ITER) begin
                            out_prob  <= prob_nx;
                            out_valid <= 1'b1;
                            out_last  <= (idx == LAST_IDX);
                            div_cnt   <= 5'd0;
                            state     <= S_OUT;
                        end else begin
                            div_cnt <= div_cnt + 5'd1;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state <= S_ACCUM;
                            acc   <= '0;
                            count <= '0;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_DIV;
                        end
                    end
                end
                default: state <= S_ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_norm.sv
// tb/tb_softmax_norm.sv - randomized bench for softmax_norm against a division-based reference model
module tb_softmax_norm;

`ifdef SOFTMAX_NORM_ROUND_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 17;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [20:0] in_exp;
    logic [15:0] out_prob;
    logic        in_valid1, in_ready1, out_valid1, out_ready1, out_last1, busy1;
    logic [20:0] in_exp1;
    logic [15:0] out_prob1;

    int n_cmp = 0;
    int n_bad = 0;

    softmax_norm #(.N(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_exp(in_exp),
        .out_valid(out_valid), .out_ready(out_ready), .out_prob(out_prob),
        .out_last(out_last), .busy(busy)
    );

    softmax_norm #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_exp(in_exp1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_prob(out_prob1),
        .out_last(out_last1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint unsigned to_fixed(input logic [20:0] w);
        int p;
        p = (w[20:16] > 5'd16) ? 16 : int'(w[20:16]);
        return longint'(w[15:0]) << p;
    endfunction

    function automatic logic [15:0] ref_prob(input longint unsigned f, input longint unsigned s);
        longint unsigned q;
        if (s == 0) return 16'h0000;
`ifdef SOFTMAX_NORM_ROUND_EN
        q = (f << 17) / s;
        q = (q + 1) >> 1;
`else
        q = (f << 16) / s;
`endif
        if (q > 64'd65535) return 16'hFFFF;
        return q[15:0];
    endfunction

    task automatic push(input logic [20:0] w);
        @(negedge clk);
        in_valid = 1'b1;
        in_exp   = w;
        check("in_ready_accum", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_exp   = 21'($urandom);
        check("busy_after_push", 64'(busy), 64'd1);
    endtask

    task automatic collect(input logic [15:0] exp_prob, input bit exp_last, input int stall);
        int lat = 0;
        in_valid = 1'($urandom_range(0, 1));
        in_exp   = 21'($urandom);
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!out_valid && lat < 60);
        check("latency", 64'(lat), 64'(LAT));
        check("out_prob", 64'(out_prob), 64'(exp_prob));
        check("out_last", 64'(out_last), 64'(exp_last));
        check("in_ready_busy", 64'(in_ready), 64'd0);
        check("busy_out", 64'(busy), 64'd1);
        repeat (stall) begin
            @(posedge clk);
            #1;
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_prob", 64'(out_prob), 64'(exp_prob));
            check("hold_last", 64'(out_last), 64'(exp_last));
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic run_vector(input logic [20:0] v [4], input int stall_min, input int stall_max);
        longint unsigned sum = 0;
        for (int i = 0; i < 4; i++) sum += to_fixed(v[i]);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            push(v[i]);
        end
        for (int i = 0; i < 4; i++)
            collect(ref_prob(to_fixed(v[i]), sum), i == 3, $urandom_range(stall_min, stall_max));
        @(negedge clk);
        check("drained_in_ready", 64'(in_ready), 64'd1);
        check("drained_busy", 64'(busy), 64'd0);
        check("drained_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [20:0] v [4];
        logic [20:0] one;
        longint unsigned sum;
        int lat;
        one = {5'd1, 16'h8000};
        rst = 1'b1;
        in_valid = 1'b0; in_exp = '0; out_ready = 1'b0;
        in_valid1 = 1'b0; in_exp1 = '0; out_ready1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_prob", 64'(out_prob), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        v = '{one, one, one, one};
        run_vector(v, 0, 1);
        v = '{{5'd1, 16'h8000}, {5'd2, 16'h8000}, {5'd3, 16'h8000}, {5'd1, 16'h8000}};
        run_vector(v, 0, 2);
        v = '{{5'd2, 16'h8000}, {5'd1, 16'h8000}, 21'd0, 21'd0};
        run_vector(v, 0, 2);
        v = '{{5'd3, 16'h0000}, {5'd9, 16'h0000}, 21'd0, {5'd16, 16'h0000}};
        run_vector(v, 0, 1);
        v = '{one, {5'd20, 16'h1234}, {5'd0, 16'h0001}, {5'd16, 16'hFFFF}};
        run_vector(v, 5, 5);

        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < 4; i++) begin
                v[i] = {5'($urandom_range(0, 20)), 16'($urandom)};
                if ($urandom_range(0, 3) == 0) v[i][15:0] = 16'd0;
            end
            run_vector(v, 0, 3);
        end

        // Reset while element 2 is in the divider.
        v = '{{5'd2, 16'h8000}, one, one, one};
        sum = 0;
        for (int i = 0; i < 4; i++) sum += to_fixed(v[i]);
        for (int i = 0; i < 4; i++) push(v[i]);
        collect(ref_prob(to_fixed(v[0]), sum), 1'b0, 0);
        collect(ref_prob(to_fixed(v[1]), sum), 1'b0, 1);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        v = '{one, one, one, one};
        for (int i = 0; i < 4; i++) push(v[i]);
        for (int i = 0; i < 4; i++) collect(16'h4000, i == 3, 0);

        // Single-element vector with a clamped exponent.
        @(negedge clk);
        in_valid1 = 1'b1;
        in_exp1   = {5'd20, 16'h0001};
        @(posedge clk);
        #1 in_valid1 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!out_valid1 && lat < 60);
        check("n1_latency", 64'(lat), 64'(LAT));
        check("n1_prob", 64'(out_prob1), 64'hFFFF);
        check("n1_last", 64'(out_last1), 64'd1);
        out_ready1 = 1'b1;
        @(posedge clk);
        #1 out_ready1 = 1'b0;
        check("n1_in_ready", 64'(in_ready1), 64'd1);
        check("n1_valid_drop", 64'(out_valid1), 64'd0);
        check("n1_busy", 64'(busy1), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
